aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
- Iterative AES-128 encryption controller. It owns the 128-bit cipher state register and instantiates the team's combinational subBytes, shiftRows, mixColumns and addRoundKey stages.
- It sequences one round per accepted round key, with NUM_ROUNDS+1 key applications per block.
- Round keys come from an external key-schedule block over a request/valid handshake. Plaintext enters and ciphertext leaves on valid/ready streams.

Parameters:
- NUM_ROUNDS, 10, number of cipher rounds. Legal values are 10, 12 and 14; other values fail elaboration.

Ports:
- clk  input  1  sole clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  plaintext available.
- in_ready  output  1  block can accept plaintext.
- in_data  input  [0:127]  plaintext; bits [0:7] are byte 0; bytes are column-major.
- rk_req  output  1  round key requested.
- rk_idx  output  4  index of the requested round key, 0..NUM_ROUNDS.
- rk_key  input  [0:127]  round key for rk_idx.
- rk_valid  input  1  rk_key is valid for the current rk_idx.
- out_valid  output  1  ciphertext available.
- out_ready  input  1  consumer accepts ciphertext.
- out_data  output  [0:127]  ciphertext; equals the state register.
- busy  output  1  high in every state except IDLE.

Behaviour:
- States: IDLE, KEY0, ROUND, FINAL, DONE. Encoding is free.
- Reset (asynchronous, any state, including mid-block):
  - state=IDLE; state register=0; round counter=0.
  - in_ready=1; rk_req=0; rk_idx=0; out_valid=0; busy=0.
  - Any block in flight is discarded; no partial output is ever flagged valid.
- IDLE:
  - in_ready=1.
  - When in_valid & in_ready: state register <= in_data, round counter <= 0, go to KEY0.
- KEY0:
  - rk_req=1, rk_idx=0.
  - On rk_valid: state <= state ^ rk_key (AddRoundKey only), counter <= 1, go to ROUND.
  - NUM_ROUNDS>1 always holds for legal values.
- ROUND:
  - rk_req=1, rk_idx=counter.
  - On rk_valid: state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), rk_key) and counter++.
  - If the new counter equals NUM_ROUNDS, go to FINAL.
- FINAL:
  - rk_req=1, rk_idx=NUM_ROUNDS.
  - On rk_valid: state <= AddRoundKey(ShiftRows(SubBytes(state)), rk_key), with MixColumns bypassed. Go to DONE.
- DONE:
  - out_valid=1; out_data is stable until accepted.
  - On out_ready: out_valid drops next cycle, go to IDLE.
  - in_ready stays 0 in DONE; there is no overlap or back-to-back bypass.
- rk_valid wait:
  - While rk_req=1 and rk_valid=0, the state register, counter and rk_idx hold.
  - rk_req remains asserted and any number of wait cycles is allowed.
- rk_valid outside a request: rk_valid while rk_req=0 is ignored.
- Registered outputs: rk_req, rk_idx, in_ready, out_valid and busy are registered outputs, derived from the state only. No combinational path runs from any input to any output.
- Latency with rk_valid tied high and out_ready high:
  - Acceptance at edge N gives out_valid=1 in the cycle after edge N+NUM_ROUNDS+1 (11 key-apply edges for AES-128).
  - Block-to-block throughput is one block per NUM_ROUNDS+3 cycles.
- Counter:
  - 4-bit and never wraps; values above NUM_ROUNDS are unreachable.
  - Formal property: rk_idx <= NUM_ROUNDS always.
- Input stability: in_data is sampled only on the accept edge. Later changes have no effect.
- Output stalls: out_ready low for any duration holds out_data and out_valid unchanged.

Test Plan:
- FIPS-197 C.1 vector:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f (round keys from a reference model), plaintext 00112233445566778899aabbccddeeff, rk_valid and out_ready tied 1.
  - Required: out_data = 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 12 cycles after the accept edge.
  - Required: rk_idx steps 0,1,...,10 with one value per cycle.
- Key stalls:
  - Stimulus: same vector; rk_valid asserted only every 3rd cycle of a request.
  - Required: identical ciphertext; rk_idx is held during waits; total latency is 34 cycles.
- Output backpressure:
  - Stimulus: out_ready=0 for 20 cycles after out_valid rises.
  - Required: out_data and out_valid stable; in_ready=0 throughout.
  - Required: after out_ready=1 for one edge, out_valid=0 and in_ready=1 on the next cycle.
- Reset mid-block:
  - Stimulus: assert reset asynchronously (off the clock edge) in ROUND with counter=5.
  - Required: immediately rk_req=0, busy=0, in_ready=1, out_data=0.
  - Required: the next block encrypts correctly.
- Back-to-back blocks:
  - Stimulus: two plaintexts held on in_valid continuously: the C.1 vector, then all-zero plaintext under key 0.
  - Required: outputs 69c4e0d8…c55a then 66e94bd4ef8a2c3b884cfa59ca342b2e, in order; the second in_data is not accepted before the first output handshake.
- Spurious key valid:
  - Stimulus: rk_valid pulses while in IDLE and DONE.
  - Required: no state change; the ciphertext is unaffected.

Source files
------------

// File: rtl/aes_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_sequencer
// Brief    : Iterative AES encryption controller; one round per accepted key.
// Revision : 1.0 - initial release
// ============================================================================
module aes_round_sequencer #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_data,
    output logic         rk_req,
    output logic [3:0]   rk_idx,
    input  logic [0:127] rk_key,
    input  logic         rk_valid,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data,
    output logic         busy
);

    if (NUM_ROUNDS != 10 && NUM_ROUNDS != 12 && NUM_ROUNDS != 14) begin : g_illegal_num_rounds
        $error("aes_round_sequencer: NUM_ROUNDS must be 10, 12 or 14");
    end

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_key0  = 3'd1;
    localparam logic [2:0] c_st_round = 3'd2;
    localparam logic [2:0] c_st_final = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    localparam logic [3:0] c_last_round = 4'(NUM_ROUNDS);

    // Byte 0 of the table sits in the top bits.
    localparam logic [2047:0] c_sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return c_sbox[(255 - int'(b)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i*8 +: 8] = sbox(s[i*8 +: 8]);
        end
        return r;
    endfunction

    // Byte (4*c + r) occupies bits [(15-(4*c+r))*8 +: 8]; row r rotates left by r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[(15 - (4*c + r))*8 +: 8] = s[(15 - (4*((c + r) % 4) + r))*8 +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[(3 - c)*32 +: 32];
            o[(3 - c)*32 +: 32] = {
                xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
            };
        end
        return o;
    endfunction

    function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
        return s ^ k;
    endfunction

    logic [2:0]   r_fsm;
    logic [3:0]   r_cnt;
    logic [127:0] r_state;
    logic         r_in_ready;
    logic         r_rk_req;
    logic         r_out_valid;
    logic         r_busy;

    logic [2:0]   w_fsm_nxt;
    logic [3:0]   w_cnt_nxt;
    logic [3:0]   w_cnt_inc;
    logic [127:0] w_state_nxt;
    logic [127:0] w_in;
    logic [127:0] w_rk;
    logic [127:0] w_sr;
    logic [127:0] w_mix;

    assign w_in      = in_data;
    assign w_rk      = rk_key;
    assign w_sr      = shift_rows(sub_bytes(r_state));
    assign w_mix     = mix_columns(w_sr);
    assign w_cnt_inc = r_cnt + 4'd1;

    // rk_valid is only looked at in the three key-request states.
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_cnt_nxt   = r_cnt;
        w_state_nxt = r_state;
        case (r_fsm)
            c_st_idle: begin
                if (in_valid && r_in_ready) begin
                    w_state_nxt = w_in;
                    w_cnt_nxt   = 4'd0;
                    w_fsm_nxt   = c_st_key0;
                end
            end
            c_st_key0: begin
                if (rk_valid) begin
                    w_state_nxt = add_round_key(r_state, w_rk);
                    w_cnt_nxt   = 4'd1;
                    w_fsm_nxt   = c_st_round;
                end
            end
            c_st_round: begin
                if (rk_valid) begin
                    w_state_nxt = add_round_key(w_mix, w_rk);
                    w_cnt_nxt   = w_cnt_inc;
                    if (w_cnt_inc == c_last_round) begin
                        w_fsm_nxt = c_st_final;
                    end
                end
            end
            c_st_final: begin
                if (rk_valid) begin
                    w_state_nxt = add_round_key(w_sr, w_rk);
                    w_fsm_nxt   = c_st_done;
                end
            end
            c_st_done: begin
                if (out_ready) begin
                    w_cnt_nxt = 4'd0;
                    w_fsm_nxt = c_st_idle;
                end
            end
            default: begin
                w_cnt_nxt = 4'd0;
                w_fsm_nxt = c_st_idle;
            end
        endcase
    end

    // Status outputs are flopped from the next-state decode so they line up
    // with r_fsm without any input-to-output path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsm       <= c_st_idle;
            r_cnt       <= 4'd0;
            r_state     <= '0;
            r_in_ready  <= 1'b1;
            r_rk_req    <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_fsm       <= w_fsm_nxt;
            r_cnt       <= w_cnt_nxt;
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_fsm_nxt == c_st_idle);
            r_rk_req    <= (w_fsm_nxt == c_st_key0) || (w_fsm_nxt == c_st_round) ||
                           (w_fsm_nxt == c_st_final);
            r_out_valid <= (w_fsm_nxt == c_st_done);
            r_busy      <= (w_fsm_nxt != c_st_idle);
        end
    end

    assign in_ready  = r_in_ready;
    assign rk_req    = r_rk_req;
    assign rk_idx    = r_cnt;
    assign out_valid = r_out_valid;
    assign out_data  = r_state;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_round_sequencer
// Brief    : Directed-vector bench for aes_round_sequencer with a key-schedule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_round_sequencer;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] in_data;
    logic         rk_req;
    logic [3:0]   rk_idx;
    logic [0:127] rk_key;
    logic         rk_valid;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] out_data;
    logic         busy;

    aes_round_sequencer #(.NUM_ROUNDS(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rk_req    (rk_req),
        .rk_idx    (rk_idx),
        .rk_key    (rk_key),
        .rk_valid  (rk_valid),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2047:0] c_sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        bit           stall;
        int           cyc;
    } vec_t;

    vec_t         vecs [4];
    logic [127:0] rk_tab [0:10];
    int           idx_log [$];
    int           n_checks;
    int           n_fail;
    bit           stall_mode;
    bit           spurious;
    int           stall_cnt;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] sb(input logic [7:0] b);
        return c_sbox[(255 - int'(b)) * 8 +: 8];
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[(3 - i)*32 +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // External key-schedule model: answers requests, optionally every 3rd cycle.
    initial begin
        stall_cnt = 0;
        rk_valid  = 1'b0;
        rk_key    = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_cnt = 0;
                rk_valid  = 1'b0;
            end else if (rk_req) begin
                check("rk_idx_range", {124'd0, rk_idx} <= 128'd10, 128'd1);
                idx_log.push_back(int'(rk_idx));
                stall_cnt++;
                rk_valid = stall_mode ? (stall_cnt == 3) : 1'b1;
                if (rk_valid) stall_cnt = 0;
                rk_key = (rk_idx <= 4'd10) ? rk_tab[rk_idx] : '0;
            end else begin
                stall_cnt = 0;
                rk_valid  = spurious ? 1'($urandom_range(0, 1)) : !stall_mode;
                rk_key    = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    task automatic do_block(input logic [127:0] pt, input logic [127:0] ct, input int exp_cyc,
                            input int rep, input string tag);
        int t;
        int cyc;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = pt;
        idx_log.delete();
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = ~pt;
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_out_valid"}, out_valid, 1);
        check({tag, "_latency"}, cyc, exp_cyc);
        check({tag, "_ct"}, out_data, ct);
        check({tag, "_done_in_ready"}, in_ready, 0);
        check({tag, "_idx_count"}, idx_log.size(), 11 * rep);
        for (int i = 0; i < idx_log.size() && i < 11 * rep; i++) begin
            check({tag, "_idx_seq"}, idx_log[i], i / rep);
        end
        if (out_ready) begin
            @(posedge clk);
            #1;
            check({tag, "_post_out_valid"}, out_valid, 0);
            check({tag, "_post_in_ready"}, in_ready, 1);
            check({tag, "_post_busy"}, busy, 0);
        end
    endtask

    initial begin
        int t;
        int n_acc;
        int n_hs;
        int ready_bad;
        int acc_t [2];
        int hs_t [2];
        logic [127:0] hs_data [2];
        logic acc;
        logic hs;
        logic [127:0] snap;

        n_checks   = 0;
        n_fail     = 0;
        stall_mode = 1'b0;
        spurious   = 1'b0;
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        acc_t      = '{0, 0};
        hs_t       = '{0, 0};
        hs_data    = '{128'd0, 128'd0};

        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, 12};
        vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1, 34};
        vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32, 1'b0, 12};
        vecs[3] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 1'b0, 12};

        #3 reset = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_rk_req", rk_req, 0);
        check("rst_rk_idx", rk_idx, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;

        for (int v = 0; v < 4; v++) begin
            expand_key(vecs[v].key);
            stall_mode = vecs[v].stall;
            do_block(vecs[v].pt, vecs[v].ct, vecs[v].cyc, vecs[v].stall ? 3 : 1, $sformatf("vec%0d", v));
        end
        stall_mode = 1'b0;

        // Output backpressure with spurious key strobes in DONE and IDLE.
        expand_key(vecs[0].key);
        out_ready = 1'b0;
        do_block(vecs[0].pt, vecs[0].ct, 12, 1, "bp");
        in_valid = 1'b1;
        in_data  = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        spurious = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, vecs[0].ct);
            check("bp_in_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("idle_spur_busy", busy, 0);
            check("idle_spur_rk_req", rk_req, 0);
            check("idle_spur_data", out_data, vecs[0].ct);
        end
        spurious = 1'b0;

        // Asynchronous reset while ROUND is waiting with counter 5.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = vecs[0].pt;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        t = 0;
        while (!(rk_req && rk_idx == 4'd5) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("mid_reached_round5", {127'd0, rk_req && rk_idx == 4'd5}, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rk_req", rk_req, 0);
        check("mid_busy", busy, 0);
        check("mid_in_ready", in_ready, 1);
        check("mid_out_data", out_data, 0);
        check("mid_out_valid", out_valid, 0);
        check("mid_rk_idx", rk_idx, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        expand_key(vecs[2].key);
        do_block(vecs[2].pt, vecs[2].ct, 12, 1, "after_reset");

        // Back-to-back: in_valid held across two blocks with different keys.
        expand_key(vecs[0].key);
        out_ready = 1'b1;
        n_acc = 0;
        n_hs = 0;
        ready_bad = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = vecs[0].pt;
        for (int k = 0; k < 80 && n_hs < 2; k++) begin
            acc  = in_valid && in_ready;
            hs   = out_valid && out_ready;
            snap = out_data;
            @(posedge clk);
            #1;
            if (acc && n_acc < 2) begin
                acc_t[n_acc] = k;
                n_acc++;
                if (n_acc == 1) in_data = vecs[3].pt;
                else in_valid = 1'b0;
            end
            if (hs && n_hs < 2) begin
                hs_t[n_hs]    = k;
                hs_data[n_hs] = snap;
                n_hs++;
                if (n_hs == 1) expand_key(vecs[3].key);
            end
            if (busy && in_ready) ready_bad++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("b2b_accepts", n_acc, 2);
        check("b2b_handshakes", n_hs, 2);
        check("b2b_ct0", hs_data[0], vecs[0].ct);
        check("b2b_ct1", hs_data[1], vecs[3].ct);
        check("b2b_order", {127'd0, acc_t[1] > hs_t[0]}, 1);
        check("b2b_throughput", acc_t[1] - acc_t[0], 13);
        check("b2b_ready_while_busy", ready_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
